alu_seq: RTL and testbench

Parametrised sequential ALU, successor to the 4-bit combinational ALU in the CPU datapath. It has a generic data width, a valid/ready input handshake, registered results, and persistent carry/zero flags for the controller's conditional jumps. It adds carry-chained arithmetic (ADC/SBB), multi-bit shifts and an iterative shift-add multiplier. It sits between the register file read ports and the mem_to_reg mux; the controller stalls the PC while `busy` is high.

---
 rtl/alu_seq.sv | 248 ++++++++++++++++++++++++
 tb/tb_alu_seq.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Sequential ALU with a valid/ready request handshake, registered result, persistent
// carry/zero flags, carry-chained ADC/SBB, serial shifts and a shift-add multiplier.
module alu_seq #(
   parameter int unsigned WIDTH  = 8,
   parameter int unsigned MUL_EN = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       alu_func,
   input  logic [WIDTH-1:0] alu_in1,
   input  logic [WIDTH-1:0] alu_in2,
   output logic             out_valid,
   output logic [WIDTH-1:0] result,
   output logic             Carry_f,
   output logic             Zero_f,
   output logic             busy,
   output logic             illegal_op
);

   localparam int unsigned SW = $clog2(WIDTH);
   localparam int unsigned CW = $clog2(WIDTH + 1);
   localparam int unsigned EW = WIDTH + 1;

   localparam logic [3:0] OP_ADD = 4'd0;
   localparam logic [3:0] OP_SUB = 4'd1;
   localparam logic [3:0] OP_AND = 4'd2;
   localparam logic [3:0] OP_OR  = 4'd3;
   localparam logic [3:0] OP_XOR = 4'd4;
   localparam logic [3:0] OP_NOT = 4'd5;
   localparam logic [3:0] OP_ROL = 4'd6;
   localparam logic [3:0] OP_ROR = 4'd7;
   localparam logic [3:0] OP_ADC = 4'd8;
   localparam logic [3:0] OP_SBB = 4'd9;
   localparam logic [3:0] OP_SHL = 4'd10;
   localparam logic [3:0] OP_SHR = 4'd11;
   localparam logic [3:0] OP_MUL = 4'd12;
   localparam logic [3:0] OP_CMP = 4'd13;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_MUL   = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] w_q, w_d;
   logic [WIDTH-1:0] mh_q, mh_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             left_q, left_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             carry_q, carry_d;
   logic             zero_q, zero_d;
   logic             valid_q, valid_d;
   logic             illegal_q, illegal_d;

   logic [EW-1:0]    ext_c;
   logic [WIDTH-1:0] res_c;
   logic [SW-1:0]    amt_c;
   logic             done_c;
   logic             cflag_c;
   logic             cupd_c;
   logic             ill_c;
   logic             cmp_c;

   // State and datapath registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= S_IDLE;
         a_q       <= '0;
         w_q       <= '0;
         mh_q      <= '0;
         cnt_q     <= '0;
         left_q    <= 1'b0;
         result_q  <= '0;
         carry_q   <= 1'b0;
         zero_q    <= 1'b0;
         valid_q   <= 1'b0;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         a_q       <= a_d;
         w_q       <= w_d;
         mh_q      <= mh_d;
         cnt_q     <= cnt_d;
         left_q    <= left_d;
         result_q  <= result_d;
         carry_q   <= carry_d;
         zero_q    <= zero_d;
         valid_q   <= valid_d;
         illegal_q <= illegal_d;
      end
   end

   // Next-state, datapath and completion logic
   always_comb begin
      state_d   = state_q;
      a_d       = a_q;
      w_d       = w_q;
      mh_d      = mh_q;
      cnt_d     = cnt_q;
      left_d    = left_q;
      result_d  = result_q;
      carry_d   = carry_q;
      zero_d    = zero_q;
      valid_d   = 1'b0;
      illegal_d = 1'b0;
      ext_c     = '0;
      res_c     = '0;
      done_c    = 1'b0;
      cflag_c   = 1'b0;
      cupd_c    = 1'b0;
      ill_c     = 1'b0;
      cmp_c     = 1'b0;
      amt_c     = alu_in2[SW-1:0];

      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               done_c = 1'b1;
               cupd_c = 1'b1;
               case (alu_func)
                  OP_ADD: begin
                     ext_c   = EW'(alu_in1) + EW'(alu_in2);
                     res_c   = ext_c[WIDTH-1:0];
                     cflag_c = ext_c[WIDTH];
                  end
                  OP_SUB: begin
                     ext_c   = EW'(alu_in1) - EW'(alu_in2);
                     res_c   = ext_c[WIDTH-1:0];
                     cflag_c = ext_c[WIDTH];
                  end
                  OP_AND: res_c = alu_in1 & alu_in2;
                  OP_OR:  res_c = alu_in1 | alu_in2;
                  OP_XOR: res_c = alu_in1 ^ alu_in2;
                  OP_NOT: res_c = ~alu_in1;
                  OP_ROL: begin
                     res_c   = {alu_in1[WIDTH-2:0], alu_in1[WIDTH-1]};
                     cflag_c = alu_in1[WIDTH-1];
                  end
                  OP_ROR: begin
                     res_c   = {alu_in1[0], alu_in1[WIDTH-1:1]};
                     cflag_c = alu_in1[0];
                  end
                  OP_ADC: begin
                     ext_c   = EW'(alu_in1) + EW'(alu_in2) + EW'(carry_q);
                     res_c   = ext_c[WIDTH-1:0];
                     cflag_c = ext_c[WIDTH];
                  end
                  OP_SBB: begin
                     ext_c   = EW'(alu_in1) - EW'(alu_in2) - EW'(carry_q);
                     res_c   = ext_c[WIDTH-1:0];
                     cflag_c = ext_c[WIDTH];
                  end
                  OP_SHL, OP_SHR: begin
                     cupd_c = 1'b0;
                     if (amt_c == '0) begin
                        res_c = alu_in1;
                     end else begin
                        done_c  = 1'b0;
                        w_d     = alu_in1;
                        cnt_d   = CW'(amt_c);
                        left_d  = (alu_func == OP_SHL);
                        state_d = S_SHIFT;
                     end
                  end
                  OP_MUL: begin
                     if (MUL_EN != 0) begin
                        done_c  = 1'b0;
                        cupd_c  = 1'b0;
                        a_d     = alu_in1;
                        w_d     = alu_in2;
                        mh_d    = '0;
                        cnt_d   = CW'(WIDTH);
                        state_d = S_MUL;
                     end else begin
                        ill_c = 1'b1;
                     end
                  end
                  OP_CMP: begin
                     ext_c   = EW'(alu_in1) - EW'(alu_in2);
                     res_c   = alu_in1;
                     cflag_c = ext_c[WIDTH];
                     cmp_c   = 1'b1;
                  end
                  default: ill_c = 1'b1;
               endcase
            end
         end

         S_SHIFT: begin
            if (left_q) begin
               w_d     = {w_q[WIDTH-2:0], 1'b0};
               cflag_c = w_q[WIDTH-1];
            end else begin
               w_d     = {1'b0, w_q[WIDTH-1:1]};
               cflag_c = w_q[0];
            end
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               done_c  = 1'b1;
               cupd_c  = 1'b1;
               res_c   = w_d;
               state_d = S_IDLE;
            end
         end

         S_MUL: begin
            // {mh_q, w_q} is the running product; w_q's LSB is the current multiplier bit
            ext_c   = EW'(mh_q) + (w_q[0] ? EW'(a_q) : EW'(0));
            mh_d    = ext_c[WIDTH:1];
            w_d     = {ext_c[0], w_q[WIDTH-1:1]};
            cflag_c = |ext_c[WIDTH:1];
            cnt_d   = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               done_c  = 1'b1;
               cupd_c  = 1'b1;
               res_c   = w_d;
               state_d = S_IDLE;
            end
         end

         default: state_d = S_IDLE;
      endcase

      if (done_c) begin
         valid_d  = 1'b1;
         result_d = res_c;
         if (ill_c) begin
            illegal_d = 1'b1;
         end else begin
            zero_d = cmp_c ? (ext_c[WIDTH-1:0] == '0) : (res_c == '0);
            if (cupd_c) carry_d = cflag_c;
         end
      end
   end

   assign in_ready   = (state_q == S_IDLE);
   assign busy       = ~in_ready;
   assign out_valid  = valid_q;
   assign result     = result_q;
   assign Carry_f    = carry_q;
   assign Zero_f     = zero_q;
   assign illegal_op = illegal_q;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: directed vector table, multi-cycle corner sequences and random
// operations checked against an arithmetic reference model, on 8-bit and 4-bit instances.
module tb_alu_seq;

   logic       clk = 1'b0;
   logic       reset;
   always #5 clk = ~clk;

   logic       in_valid, in_ready, out_valid, Carry_f, Zero_f, busy, illegal_op;
   logic [3:0] alu_func;
   logic [7:0] alu_in1, alu_in2, result;

   logic       q_in_valid, q_in_ready, q_out_valid, q_Carry_f, q_Zero_f, q_busy, q_illegal_op;
   logic [3:0] q_alu_func, q_alu_in1, q_alu_in2, q_result;

   alu_seq #(.WIDTH(8), .MUL_EN(1)) u_dut8 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .alu_func(alu_func), .alu_in1(alu_in1), .alu_in2(alu_in2),
      .out_valid(out_valid), .result(result), .Carry_f(Carry_f), .Zero_f(Zero_f),
      .busy(busy), .illegal_op(illegal_op)
   );

   alu_seq #(.WIDTH(4), .MUL_EN(0)) u_dut4 (
      .clk(clk), .reset(reset), .in_valid(q_in_valid), .in_ready(q_in_ready),
      .alu_func(q_alu_func), .alu_in1(q_alu_in1), .alu_in2(q_alu_in2),
      .out_valid(q_out_valid), .result(q_result), .Carry_f(q_Carry_f), .Zero_f(q_Zero_f),
      .busy(q_busy), .illegal_op(q_illegal_op)
   );

   typedef struct {
      logic [3:0] f;
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] res;
      logic       c;
      logic       z;
      logic       ill;
      int         lat;
   } vec_t;

   vec_t       tbl[$];
   int         n_vec = 0;
   int         n_err = 0;
   bit         m_c, m_z, m4_c, m4_z;

   logic [3:0] rf;
   logic [7:0] ra, rb, o_res;
   logic       o_c, o_z, o_ill, o_bz, o_after;
   int         o_lat, cnt;
   longint     e_res;
   bit         e_c, e_z, e_ill;
   int         e_lat;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Reference behaviour from the opcode definitions, using plain integer arithmetic
   function automatic void model(input int w, input int f, input longint a, input longint b,
                                 input bit cin, input bit zin, input bit mul_en,
                                 output longint res, output bit c, output bit z,
                                 output bit ill, output int lat);
      longint md = longint'(1) << w;
      int     sw = $clog2(w);
      longint n  = b % (longint'(1) << sw);
      longint s;
      res = 0; c = cin; z = zin; ill = 0; lat = 0;
      case (f)
         0:  begin s = a + b; res = s % md; c = (s >= md); end
         1:  begin res = (a - b + md) % md; c = (a < b); end
         2:  begin res = a & b; c = 0; end
         3:  begin res = a | b; c = 0; end
         4:  begin res = a ^ b; c = 0; end
         5:  begin res = (md - 1) - a; c = 0; end
         6:  begin res = ((a * 2) % md) + (a >> (w - 1)); c = bit'((a >> (w - 1)) & 1); end
         7:  begin res = (a >> 1) + (a & 1) * (md / 2); c = bit'(a & 1); end
         8:  begin s = a + b + longint'(cin); res = s % md; c = (s >= md); end
         9:  begin res = (a - b - longint'(cin) + 2 * md) % md; c = (a < b + longint'(cin)); end
         10: if (n == 0) res = a;
             else begin
                res = (a << n) % md; lat = int'(n);
                c = (n <= w) ? bit'((a >> (w - n)) & 1) : 1'b0;
             end
         11: if (n == 0) res = a;
             else begin
                res = a >> n; lat = int'(n);
                c = (n <= w) ? bit'((a >> (n - 1)) & 1) : 1'b0;
             end
         12: if (mul_en) begin
                s = a * b; res = s % md; c = ((s / md) != 0); lat = w;
             end else ill = 1;
         13: begin res = a; c = (a < b); z = (a == b); end
         default: ill = 1;
      endcase
      if (!ill && f != 13) z = (res == 0);
   endfunction

   // Issue one op on the 8-bit instance and observe its completion
   task automatic do_op(input logic [3:0] f, input logic [7:0] a, input logic [7:0] b,
                        output logic [7:0] r, output logic c, output logic z, output logic ill,
                        output int lat, output logic bz, output logic after);
      int g = 0;
      @(negedge clk);
      in_valid = 1'b1; alu_func = f; alu_in1 = a; alu_in2 = b;
      while (!in_ready && g < 100) begin @(negedge clk); g++; end
      @(posedge clk); #1 in_valid = 1'b0;
      @(negedge clk);
      bz = busy; lat = 0;
      while (!out_valid && lat < 100) begin @(negedge clk); lat++; end
      r = result; c = Carry_f; z = Zero_f; ill = illegal_op;
      @(negedge clk);
      after = out_valid;
   endtask

   task automatic check_op(input string tag, input logic [7:0] xr, input logic xc,
                           input logic xz, input logic xi, input int xl);
      chk({tag, " result"}, 32'(o_res), 32'(xr));
      chk({tag, " carry"}, 32'(o_c), 32'(xc));
      chk({tag, " zero"}, 32'(o_z), 32'(xz));
      chk({tag, " illegal"}, 32'(o_ill), 32'(xi));
      chk({tag, " latency"}, 32'(o_lat), 32'(xl));
      chk({tag, " busy"}, 32'(o_bz), 32'(xl > 0));
      chk({tag, " pulse_len"}, 32'(o_after), 32'd0);
   endtask

   // Issue one op on the 4-bit instance
   task automatic do_op4(input logic [3:0] f, input logic [3:0] a, input logic [3:0] b,
                         output logic [3:0] r, output logic c, output logic z, output logic ill,
                         output int lat);
      @(negedge clk);
      q_in_valid = 1'b1; q_alu_func = f; q_alu_in1 = a; q_alu_in2 = b;
      @(posedge clk); #1 q_in_valid = 1'b0;
      @(negedge clk);
      lat = 0;
      while (!q_out_valid && lat < 50) begin @(negedge clk); lat++; end
      r = q_result; c = q_Carry_f; z = q_Zero_f; ill = q_illegal_op;
      @(negedge clk);
   endtask

   task automatic run4(input string tag, input logic [3:0] f, input logic [3:0] a,
                       input logic [3:0] b);
      logic [3:0] r;
      logic       c, z, ill;
      int         lat;
      longint     xr;
      bit         xc, xz, xi;
      int         xl;
      model(4, int'(f), longint'(a), longint'(b), m4_c, m4_z, 1'b0, xr, xc, xz, xi, xl);
      do_op4(f, a, b, r, c, z, ill, lat);
      chk({tag, " w4 result"}, 32'(r), 32'(xr));
      chk({tag, " w4 carry"}, 32'(c), 32'(xc));
      chk({tag, " w4 zero"}, 32'(z), 32'(xz));
      chk({tag, " w4 illegal"}, 32'(ill), 32'(xi));
      chk({tag, " w4 latency"}, 32'(lat), 32'(xl));
      m4_c = xc; m4_z = xz;
   endtask

   initial begin
      reset = 1'b0;
      in_valid = 1'b0; alu_func = '0; alu_in1 = '0; alu_in2 = '0;
      q_in_valid = 1'b0; q_alu_func = '0; q_alu_in1 = '0; q_alu_in2 = '0;

      //            f      a      b      res    c  z  ill lat
      tbl.push_back('{4'd0,  8'hF0, 8'h20, 8'h10, 1, 0, 0, 0});
      tbl.push_back('{4'd9,  8'h05, 8'h05, 8'hFF, 1, 0, 0, 0});
      tbl.push_back('{4'd0,  8'hFF, 8'h01, 8'h00, 1, 1, 0, 0});
      tbl.push_back('{4'd8,  8'h00, 8'h00, 8'h01, 0, 0, 0, 0});
      tbl.push_back('{4'd10, 8'h81, 8'h03, 8'h08, 0, 0, 0, 3});
      tbl.push_back('{4'd11, 8'h81, 8'h01, 8'h40, 1, 0, 0, 1});
      tbl.push_back('{4'd10, 8'h55, 8'h00, 8'h55, 1, 0, 0, 0});
      tbl.push_back('{4'd1,  8'h03, 8'h05, 8'hFE, 1, 0, 0, 0});
      tbl.push_back('{4'd13, 8'h05, 8'h05, 8'h05, 0, 1, 0, 0});
      tbl.push_back('{4'd12, 8'h10, 8'h10, 8'h00, 1, 1, 0, 8});
      tbl.push_back('{4'd12, 8'h0F, 8'h0F, 8'hE1, 0, 0, 0, 8});
      tbl.push_back('{4'd5,  8'h0F, 8'h00, 8'hF0, 0, 0, 0, 0});
      tbl.push_back('{4'd4,  8'hAA, 8'hAA, 8'h00, 0, 1, 0, 0});
      tbl.push_back('{4'd15, 8'h12, 8'h34, 8'h00, 0, 1, 1, 0});
      tbl.push_back('{4'd6,  8'h80, 8'h00, 8'h01, 1, 0, 0, 0});
      tbl.push_back('{4'd7,  8'h01, 8'h00, 8'h80, 1, 0, 0, 0});
      tbl.push_back('{4'd14, 8'h00, 8'h00, 8'h00, 1, 0, 1, 0});
      tbl.push_back('{4'd11, 8'h80, 8'h07, 8'h01, 0, 0, 0, 7});

      // Reset values
      @(negedge clk); @(negedge clk);
      chk("rst result", 32'(result), 32'd0);
      chk("rst carry", 32'(Carry_f), 32'd0);
      chk("rst zero", 32'(Zero_f), 32'd0);
      chk("rst out_valid", 32'(out_valid), 32'd0);
      chk("rst illegal", 32'(illegal_op), 32'd0);
      chk("rst in_ready", 32'(in_ready), 32'd1);
      chk("rst busy", 32'(busy), 32'd0);
      chk("rst w4 result", 32'(q_result), 32'd0);
      chk("rst w4 in_ready", 32'(q_in_ready), 32'd1);
      reset = 1'b1;

      foreach (tbl[i]) begin
         do_op(tbl[i].f, tbl[i].a, tbl[i].b, o_res, o_c, o_z, o_ill, o_lat, o_bz, o_after);
         check_op($sformatf("vec%0d", i), tbl[i].res, tbl[i].c, tbl[i].z, tbl[i].ill, tbl[i].lat);
         m_c = tbl[i].c; m_z = tbl[i].z;
      end

      // ADD then ADC on consecutive edges: carry chains through
      @(negedge clk);
      in_valid = 1'b1; alu_func = 4'd0; alu_in1 = 8'hFF; alu_in2 = 8'h01;
      @(posedge clk); #1 alu_func = 4'd8; alu_in1 = 8'h00; alu_in2 = 8'h00;
      @(negedge clk);
      chk("b2b add valid", 32'(out_valid), 32'd1);
      chk("b2b add result", 32'(result), 32'h00);
      chk("b2b add carry", 32'(Carry_f), 32'd1);
      chk("b2b add zero", 32'(Zero_f), 32'd1);
      @(posedge clk); #1 in_valid = 1'b0;
      @(negedge clk);
      chk("b2b adc valid", 32'(out_valid), 32'd1);
      chk("b2b adc result", 32'(result), 32'h01);
      chk("b2b adc carry", 32'(Carry_f), 32'd0);
      chk("b2b adc zero", 32'(Zero_f), 32'd0);
      @(negedge clk);
      chk("b2b idle valid", 32'(out_valid), 32'd0);

      // MUL with a second op held on in_valid throughout
      @(negedge clk);
      in_valid = 1'b1; alu_func = 4'd12; alu_in1 = 8'h10; alu_in2 = 8'h10;
      @(posedge clk); #1 alu_func = 4'd0; alu_in1 = 8'h01; alu_in2 = 8'h02;
      @(negedge clk);
      o_lat = 0;
      while (!out_valid && o_lat < 100) begin @(negedge clk); o_lat++; end
      chk("stall mul latency", 32'(o_lat), 32'd8);
      chk("stall mul result", 32'(result), 32'h00);
      chk("stall mul carry", 32'(Carry_f), 32'd1);
      chk("stall mul zero", 32'(Zero_f), 32'd1);
      chk("stall in_ready", 32'(in_ready), 32'd1);
      @(posedge clk); #1 in_valid = 1'b0;
      @(negedge clk);
      chk("stall add valid", 32'(out_valid), 32'd1);
      chk("stall add result", 32'(result), 32'h03);
      chk("stall add carry", 32'(Carry_f), 32'd0);
      chk("stall add zero", 32'(Zero_f), 32'd0);

      // Reset three cycles into a MUL
      @(negedge clk);
      in_valid = 1'b1; alu_func = 4'd12; alu_in1 = 8'h0F; alu_in2 = 8'h0F;
      @(posedge clk); #1 in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      #1;
      chk("midrst out_valid", 32'(out_valid), 32'd0);
      chk("midrst result", 32'(result), 32'd0);
      chk("midrst carry", 32'(Carry_f), 32'd0);
      chk("midrst zero", 32'(Zero_f), 32'd0);
      chk("midrst in_ready", 32'(in_ready), 32'd1);
      chk("midrst busy", 32'(busy), 32'd0);
      chk("midrst illegal", 32'(illegal_op), 32'd0);
      @(negedge clk); reset = 1'b1;
      cnt = 0;
      repeat (12) begin @(negedge clk); if (out_valid) cnt++; end
      chk("midrst stray pulse", 32'(cnt), 32'd0);
      m_c = 0; m_z = 0; m4_c = 0; m4_z = 0;
      do_op(4'd0, 8'h02, 8'h03, o_res, o_c, o_z, o_ill, o_lat, o_bz, o_after);
      check_op("post-rst add", 8'h05, 1'b0, 1'b0, 1'b0, 0);

      // Random operations against the reference model
      repeat (150) begin
         rf = 4'($urandom_range(0, 15));
         ra = 8'($urandom);
         rb = 8'($urandom);
         model(8, int'(rf), longint'(ra), longint'(rb), m_c, m_z, 1'b1, e_res, e_c, e_z, e_ill, e_lat);
         do_op(rf, ra, rb, o_res, o_c, o_z, o_ill, o_lat, o_bz, o_after);
         check_op($sformatf("rnd f%0d a%0h b%0h", rf, ra, rb), 8'(e_res), e_c, e_z, e_ill, e_lat);
         m_c = e_c; m_z = e_z;
      end

      // 4-bit instance without multiplier
      run4("ror", 4'd7, 4'b0001, 4'd0);
      chk("w4 ror exact", 32'(q_result), 32'b1000);
      run4("rol", 4'd6, 4'b1000, 4'd0);
      chk("w4 rol exact", 32'(q_result), 32'b0001);
      run4("mul off", 4'd12, 4'd3, 4'd3);
      chk("w4 mul off carry kept", 32'(q_Carry_f), 32'd1);
      run4("shl3", 4'd10, 4'b0011, 4'd3);
      repeat (40) begin
         rf = 4'($urandom_range(0, 15));
         ra = 8'($urandom);
         rb = 8'($urandom);
         run4($sformatf("rnd4 f%0d", rf), rf, ra[3:0], rb[3:0]);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
